// File: rtl/padded_fm_reader.sv
// rtl/padded_fm_reader.sv - streams one padded feature-map frame out of a word-addressed buffer
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a frame read (sampled only when idle)
//   IFM_C, IFM_W, padding  frame shape: channels, unpadded width/height, 1-pixel zero border
//   base_addr              buffer address of the first padded word
//   rd_en, rd_addr         buffer read request
//   rd_data                buffer data, one cycle after rd_en
//   out_valid, out_ready   output handshake
//   out_data               streamed word
//   out_eol, out_last      last word of a padded row / of the frame
//   busy, done             frame in progress / one-cycle completion pulse

module padded_fm_reader #(
    parameter int PE        = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      IFM_C,
    input  logic [7:0]      IFM_W,
    input  logic            padding,
    input  logic [15:0]     base_addr,
    output logic            rd_en,
    output logic [15:0]     rd_addr,
    input  logic [PE*8-1:0] rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PE*8-1:0] out_data,
    output logic            out_eol,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam int          DW      = PE * 8;
    localparam logic [7:0]  PE_B    = 8'(PE);
    localparam logic [15:0] STEP_16 = 16'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // Latched frame geometry
    logic [7:0]  wpp;
    logic [8:0]  pw;
    logic [15:0] addr;

    // Raster position of the next read to issue
    logic [7:0]  w_idx;
    logic [8:0]  col;
    logic [8:0]  row;

    // One read in flight, with the flags computed when it was issued
    logic        inflight;
    logic        infl_eol;
    logic        infl_last;

    // Two-entry output FIFO; each entry is {last, eol, data}
    logic [DW+1:0] fifo_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [1:0]    count_nxt;

    logic [7:0]  wpp_in;
    logic [8:0]  pw_in;
    logic        frame_empty;
    logic        last_wip;
    logic        last_col;
    logic        last_row;
    logic        issue_eol;
    logic        issue_last;
    logic        head_from_fifo;
    logic [DW+1:0] head;
    logic        pop;
    logic        fifo_pop;
    logic        push;

    assign wpp_in      = IFM_C / PE_B;
    assign pw_in       = {1'b0, IFM_W} + {7'd0, padding, 1'b0};
    assign frame_empty = (wpp_in == 8'd0) || (pw_in == 9'd0);

    assign last_wip   = (w_idx == wpp - 8'd1);
    assign last_col   = (col == pw - 9'd1);
    assign last_row   = (row == pw - 9'd1);
    assign issue_eol  = last_wip && last_col;
    assign issue_last = issue_eol && last_row;

    // Credit check: stored words plus the word arriving this cycle must leave room.
    assign rd_en   = (state == READ) && (({1'b0, count} + {2'b00, inflight}) < 3'd2);
    assign rd_addr = addr;

    // When the FIFO is empty the arriving word is presented directly, so a word
    // accepted in its arrival cycle never occupies an entry; this is what keeps
    // one word per cycle flowing with only two credits.
    assign head_from_fifo = (count != 2'd0);
    assign head           = fifo_mem[rd_ptr];
    assign out_valid      = head_from_fifo || inflight;
    assign out_data       = head_from_fifo ? head[DW-1:0] : (inflight ? rd_data : '0);
    assign out_eol        = head_from_fifo ? head[DW]     : (inflight && infl_eol);
    assign out_last       = head_from_fifo ? head[DW+1]   : (inflight && infl_last);

    assign pop       = out_valid && out_ready;
    assign fifo_pop  = pop && head_from_fifo;
    assign push      = inflight && !(pop && !head_from_fifo);
    assign count_nxt = count + {1'b0, push} - {1'b0, fifo_pop};

    assign busy = (state == READ) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wpp         <= '0;
            pw          <= '0;
            addr        <= '0;
            w_idx       <= '0;
            col         <= '0;
            row         <= '0;
            inflight    <= 1'b0;
            infl_eol    <= 1'b0;
            infl_last   <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {infl_last, infl_eol, rd_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;

            inflight <= rd_en;
            if (rd_en) begin
                infl_eol  <= issue_eol;
                infl_last <= issue_last;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        wpp   <= wpp_in;
                        pw    <= pw_in;
                        addr  <= base_addr;
                        w_idx <= '0;
                        col   <= '0;
                        row   <= '0;
                        state <= frame_empty ? DONE : READ;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        addr <= addr + STEP_16;
                        if (last_wip) begin
                            w_idx <= '0;
                            if (last_col) begin
                                col <= '0;
                                row <= row + 9'd1;
                            end else begin
                                col <= col + 9'd1;
                            end
                        end else begin
                            w_idx <= w_idx + 8'd1;
                        end
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // No reads are issued here, so nothing is in flight next cycle;
                    // finishing on the accepting edge makes done follow the last word.
                    if (count_nxt == 2'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/padded_fm_reader.md
PADDED_FM_READER -- requirements
Module: padded_fm_reader

Interface
REQ-001 SHALL have parameter PE, default 16, channels per buffer word (word = PE*8 bits).
REQ-002 SHALL have parameter ADDR_STEP, default 4, address increment between consecutive buffer words.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a frame read; sampled only in IDLE.
REQ-006 SHALL have port IFM_C  input  8  channel count, a multiple of PE.
REQ-007 SHALL have port IFM_W  input  8  unpadded width (= height).
REQ-008 SHALL have port padding  input  1  1 = frame stored with a 1-pixel zero border.
REQ-009 SHALL have port base_addr  input  16  buffer address of the first padded word.
REQ-010 SHALL have port rd_en  output  1  buffer read strobe.
REQ-011 SHALL have port rd_addr  output  16  buffer read address, valid with rd_en.
REQ-012 SHALL have port rd_data  input  PE*8  buffer data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
REQ-015 SHALL have port out_data  output  PE*8  streamed word.
REQ-016 SHALL have port out_eol  output  1  high with the last word of each padded row.
REQ-017 SHALL have port out_last  output  1  high with the final word of the frame.
REQ-018 SHALL have port busy  output  1  high from frame acceptance until done.
REQ-019 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-020 SHALL latch IFM_C, IFM_W, padding and base_addr on start in IDLE; later input changes do not affect the frame.
REQ-021 SHALL derive PW = IFM_W + 2*padding (9 bits), WPP = IFM_C/PE words per pixel, and total words N = PW*PW*WPP.
REQ-022 SHALL use states IDLE, READ, DRAIN, DONE: IDLE->READ on start with N>0; IDLE->DONE on start with N=0; READ->DRAIN after the Nth read is issued; DRAIN->DONE when the output buffer is empty and no read is in flight; DONE->IDLE unconditionally.
REQ-023 SHALL issue reads in raster order: word-in-pixel fastest, then column, then row; the k-th read (k from 0) addresses base_addr + k*ADDR_STEP, wrapping modulo 2^16.
REQ-024 SHALL keep a 2-entry output FIFO and SHALL assert rd_en only in READ and only when occupancy + in-flight reads < 2.
REQ-025 SHALL write rd_data into the FIFO in the cycle after rd_en, tagged with eol/last flags computed at issue time.
REQ-026 SHALL present the FIFO head on out_data/out_eol/out_last with out_valid high while the FIFO is non-empty; head SHALL hold stable while out_valid && !out_ready.
REQ-027 SHALL sustain one word per cycle when out_ready is held high (throughput 1, first out_valid 2 cycles after start).
REQ-028 SHALL handle simultaneous FIFO push and pop in one cycle without loss or duplication.
REQ-029 SHALL assert out_eol on words with word-in-pixel = WPP-1 and column = PW-1; out_last on word N-1 only.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL drive busy high in READ and DRAIN, low in IDLE and DONE; done high only in DONE.
REQ-032 SHALL never emit data for a zero-size frame (IFM_C<PE or IFM_W=0 with padding=0): done pulses with no rd_en and no out_valid.

Reset
REQ-033 SHALL, on rst high at any clock edge (including mid-frame), enter IDLE, clear counters, FIFO and in-flight flag.
REQ-034 SHALL hold after reset: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_eol=0, out_last=0, busy=0, done=0.
REQ-035 SHALL discard any rd_data returned in the cycle after reset deasserts from a pre-reset read.

Verification
REQ-036 C=16, W=2, padding=1, base=0x0100, out_ready=1 -> 16 reads at 0x0100..0x013C step 4; out_eol on words 3,7,11,15; out_last on word 15; done one cycle after word 15 accepted.
REQ-037 C=32, W=1, padding=0, base=0xFFFC -> 2 reads at 0xFFFC then 0x0000 (wrap); out_eol and out_last both on word 1.
REQ-038 C=16, W=4, padding=0, out_ready toggled 1/0 each cycle -> 16 words delivered in order, no drops or duplicates, out_data stable during stalls, rd_en never issued with FIFO+in-flight = 2.
REQ-039 start with IFM_W=0, padding=0 -> done pulses, no rd_en, no out_valid, busy never high.
REQ-040 rst asserted after 5 words of a 36-word frame -> next edge all outputs at reset values; fresh start reads again from base_addr.
REQ-041 start pulsed again mid-frame with different config -> ignored; original frame completes unchanged.
